// File: rtl/seq_pkg.sv
// Shared types and constants for the instruction sequencer: FSM states,
// opcode encodings and the default halt word.
package seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    EXEC  = 3'd2,
    MEM   = 3'd3,
    HALT  = 3'd4
  } state_t;

  localparam logic [8:0] HALT_INSTR_DEF = 9'h1FF;

  localparam logic [2:0] OP_MEM  = 3'b010;
  localparam logic [2:0] OP_BNEQ = 3'b011;
  localparam logic [2:0] OP_BLT  = 3'b110;

  localparam int WAIT_W = 4;

  function automatic logic is_branch_op(input logic [2:0] op);
    return (op == OP_BNEQ) || (op == OP_BLT);
  endfunction

  function automatic logic is_mem_op(input logic [2:0] op);
    return op == OP_MEM;
  endfunction

endpackage

// File: rtl/seq_ctrl_pc_unit.sv
// Program counter: register plus next-PC mux (branch target or increment,
// wrapping at 2^PC_W).
module pc_unit #(
  parameter int PC_W = 10
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_clear,
  input  logic            i_update,
  input  logic            i_branch,
  input  logic            i_take_branch,
  input  logic [PC_W-1:0] i_target,
  output logic [PC_W-1:0] o_prog_ctr
);

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] w_next_pc;

  always_comb begin
    w_next_pc = r_pc + PC_W'(1);
    if (i_branch && i_take_branch) w_next_pc = i_target;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc <= '0;
    end else if (i_clear) begin
      r_pc <= '0;
    end else if (i_update) begin
      r_pc <= w_next_pc;
    end
  end

  assign o_prog_ctr = r_pc;

endmodule

// File: rtl/seq_ctrl.sv
// Multi-cycle instruction sequencer: fetch, execute, and a fixed-latency
// memory phase, with gated write/read strobes and a saturating cycle counter.
module seq_ctrl
  import seq_pkg::*;
#(
  parameter int         PC_W       = 10,
  parameter int         MEM_LAT    = 2,
  parameter logic [8:0] HALT_INSTR = HALT_INSTR_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [8:0]      instr,
  input  logic            Branch,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            RegWrite,
  input  logic            take_branch,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] prog_ctr,
  output logic [8:0]      ir,
  output logic            reg_we,
  output logic            mem_we,
  output logic            mem_re,
  output logic            busy,
  output logic            done,
  output logic [31:0]     cycle_count,
  output logic [2:0]      o_dbg_state
);

  state_t            r_state;
  logic [WAIT_W-1:0] r_wait;
  logic              r_mem_first;
  logic [8:0]        r_ir;
  logic              r_busy;
  logic              r_done;
  logic [31:0]       r_cycles;

  logic w_start_ok;
  logic w_is_mem;
  logic w_mem_last;
  logic w_pc_update;

  assign w_start_ok  = start && ((r_state == IDLE) || (r_state == HALT));
  assign w_is_mem    = MemWrite || MemtoReg;
  assign w_mem_last  = (r_state == MEM) && (r_wait == '0);
  assign w_pc_update = ((r_state == EXEC) && !w_is_mem) || w_mem_last;

  pc_unit #(.PC_W(PC_W)) u_pc (
    .clk           (clk),
    .reset         (reset),
    .i_clear       (w_start_ok),
    .i_update      (w_pc_update),
    .i_branch      (Branch),
    .i_take_branch (take_branch),
    .i_target      (target),
    .o_prog_ctr    (prog_ctr)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_wait      <= '0;
      r_mem_first <= 1'b0;
      r_ir        <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cycles    <= '0;
    end else begin
      if (r_busy && (r_cycles != 32'hFFFF_FFFF)) r_cycles <= r_cycles + 32'd1;
      case (r_state)
        IDLE, HALT: begin
          if (start) begin
            r_state  <= FETCH;
            r_cycles <= '0;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        FETCH: begin
          if (instr == HALT_INSTR) begin
            r_state <= HALT;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_ir    <= instr;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_is_mem) begin
            r_state     <= MEM;
            r_wait      <= WAIT_W'(MEM_LAT - 1);
            r_mem_first <= 1'b1;
          end else begin
            r_state <= FETCH;
          end
        end
        MEM: begin
          r_mem_first <= 1'b0;
          if (r_wait == '0) r_state <= FETCH;
          else              r_wait  <= r_wait - WAIT_W'(1);
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  // Strobes decode the registered state, so an async reset kills them at once.
  assign reg_we = ((r_state == EXEC) && !w_is_mem && RegWrite) || (w_mem_last && MemtoReg);
  assign mem_we = (r_state == MEM) && r_mem_first && MemWrite;
  assign mem_re = (r_state == MEM) && MemtoReg;

  assign ir          = r_ir;
  assign busy        = r_busy;
  assign done        = r_done;
  assign cycle_count = r_cycles;
  assign o_dbg_state = r_state;

endmodule
